// File: rtl/iq_pkg.sv
// Shared types and constants for the wakeup issue queue.
// Holds the fixed datapath widths, the stored-entry layout, the issue packet
// layout and the "no index" constant returned by the priority encoder.
package iq_pkg;

    localparam int unsigned OPC_BITS  = 7;
    localparam int unsigned PREG_BITS = 6;
    localparam int unsigned ROB_BITS  = 6;
    localparam int unsigned XLEN      = 32;

    localparam int unsigned ISSUE_W   = OPC_BITS + PREG_BITS + 3 * XLEN + ROB_BITS;

    // Index value reported when no entry qualifies (truncated to the index width).
    localparam int unsigned IQ_INVALID = 32'hFFFF_FFFF;

    // One stored queue entry (valid bit and FU id live beside it in the queue).
    typedef struct packed {
        logic [OPC_BITS-1:0]  opcode;
        logic [PREG_BITS-1:0] dest;
        logic [PREG_BITS-1:0] rs1_tag;
        logic [XLEN-1:0]      rs1_val;
        logic                 rs1_rdy;
        logic [PREG_BITS-1:0] rs2_tag;
        logic [XLEN-1:0]      rs2_val;
        logic                 rs2_rdy;
        logic [XLEN-1:0]      imm;
        logic [ROB_BITS-1:0]  rob;
    } iq_entry_t;

    // Packet handed to a functional unit; opcode occupies the MSBs.
    typedef struct packed {
        logic [OPC_BITS-1:0]  opcode;
        logic [PREG_BITS-1:0] dest;
        logic [XLEN-1:0]      rs1_val;
        logic [XLEN-1:0]      rs2_val;
        logic [XLEN-1:0]      imm;
        logic [ROB_BITS-1:0]  rob;
    } issue_pkt_t;

    function automatic issue_pkt_t to_issue(input iq_entry_t e);
        issue_pkt_t p;
        p.opcode  = e.opcode;
        p.dest    = e.dest;
        p.rs1_val = e.rs1_val;
        p.rs2_val = e.rs2_val;
        p.imm     = e.imm;
        p.rob     = e.rob;
        return p;
    endfunction

endpackage

// File: rtl/iq_select.sv
// Lowest-index priority encoder.
// Ports: elig_i  - eligibility vector
//        found_o - at least one bit of elig_i is set
//        idx_o   - index of the lowest set bit (IQ_INVALID truncated if none)
module iq_select
    import iq_pkg::*;
#(
    parameter int unsigned N     = 16,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    // Scan from the top so the lowest qualifying index is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = IDX_W'(IQ_INVALID);
        for (int i = N - 1; i >= 0; i--) begin
            if (elig_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wakeup_issue_queue.sv
// Out-of-order issue queue with CDB wakeup and per-FU oldest-slot select.
// Ports: clk/reset_n           - clock, async active-low reset
//        disp_*                - one renamed instruction per cycle, disp_ready = !full
//        cdb_valid/tag/val     - NUM_CDB result broadcasts (bus 0 in LSBs)
//        fu_ready              - per-FU accept; frees the selected entry
//        issue_valid/issue_pkt - per-FU selected packet, from entry registers only
//        flush                 - synchronous squash of every entry
//        iq_count              - occupied entries
module wakeup_issue_queue
    import iq_pkg::*;
#(
    parameter int unsigned IQ_DEPTH = 16,
    parameter int unsigned NUM_FU   = 3,
    parameter int unsigned NUM_CDB  = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [OPC_BITS-1:0]          disp_opcode,
    input  logic [PREG_BITS-1:0]         disp_dest,
    input  logic [PREG_BITS-1:0]         disp_rs1,
    input  logic [PREG_BITS-1:0]         disp_rs2,
    input  logic [XLEN-1:0]              disp_rs1_val,
    input  logic [XLEN-1:0]              disp_rs2_val,
    input  logic                         disp_rs1_rdy,
    input  logic                         disp_rs2_rdy,
    input  logic [XLEN-1:0]              disp_imm,
    input  logic [ROB_BITS-1:0]          disp_rob,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*PREG_BITS-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]      cdb_val,
    input  logic [NUM_FU-1:0]            fu_ready,
    output logic [NUM_FU-1:0]            issue_valid,
    output logic [NUM_FU*ISSUE_W-1:0]    issue_pkt,
    input  logic                         flush,
    output logic [$clog2(IQ_DEPTH):0]    iq_count
);

    localparam int unsigned IDX_W = $clog2(IQ_DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam int unsigned FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [IQ_DEPTH-1:0] valid_q, valid_d;
    iq_entry_t           ent_q [IQ_DEPTH];
    iq_entry_t           ent_d [IQ_DEPTH];
    logic [FU_W-1:0]     fu_q  [IQ_DEPTH];
    logic [FU_W-1:0]     fu_d  [IQ_DEPTH];
    logic [FU_W-1:0]     rr_q, rr_d;

    logic [CNT_W-1:0]    count_c;
    logic [IDX_W-1:0]    free_idx_c;
    iq_entry_t           disp_ent_c;
    logic [NUM_FU-1:0]   sel_found;
    logic [IDX_W-1:0]    sel_idx [NUM_FU];

    // Source capture: keep a ready operand, else take the lowest matching bus.
    function automatic logic [XLEN:0] wake(
        input logic [PREG_BITS-1:0]         tag,
        input logic                         rdy,
        input logic [XLEN-1:0]              val,
        input logic [NUM_CDB-1:0]           cv,
        input logic [NUM_CDB*PREG_BITS-1:0] ct,
        input logic [NUM_CDB*XLEN-1:0]      cd
    );
        logic [XLEN:0] res;
        res = {rdy, val};
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (!rdy && cv[b] && ct[b*PREG_BITS +: PREG_BITS] == tag) begin
                res = {1'b1, cd[b*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    // Occupancy and lowest free slot, both from registered valid bits.
    always_comb begin
        count_c    = '0;
        free_idx_c = '0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            count_c = count_c + CNT_W'(valid_q[i]);
            if (!valid_q[i]) begin
                free_idx_c = IDX_W'(i);
            end
        end
    end

    assign iq_count   = count_c;
    assign disp_ready = (count_c != CNT_W'(IQ_DEPTH));

    // Incoming instruction, with same-cycle wakeup applied to its sources.
    always_comb begin
        disp_ent_c         = '0;
        disp_ent_c.opcode  = disp_opcode;
        disp_ent_c.dest    = disp_dest;
        disp_ent_c.rs1_tag = disp_rs1;
        disp_ent_c.rs2_tag = disp_rs2;
        disp_ent_c.imm     = disp_imm;
        disp_ent_c.rob     = disp_rob;
        {disp_ent_c.rs1_rdy, disp_ent_c.rs1_val} =
            wake(disp_rs1, disp_rs1_rdy, disp_rs1_val, cdb_valid, cdb_tag, cdb_val);
        {disp_ent_c.rs2_rdy, disp_ent_c.rs2_val} =
            wake(disp_rs2, disp_rs2_rdy, disp_rs2_val, cdb_valid, cdb_tag, cdb_val);
    end

    // Per-FU select: one priority encoder per issue port.
    for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
        logic [IQ_DEPTH-1:0] elig;

        for (genvar i = 0; i < IQ_DEPTH; i++) begin : g_elig
            assign elig[i] = valid_q[i] && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy
                             && (fu_q[i] == FU_W'(k));
        end

        iq_select #(
            .N     (IQ_DEPTH),
            .IDX_W (IDX_W)
        ) u_sel (
            .elig_i  (elig),
            .found_o (sel_found[k]),
            .idx_o   (sel_idx[k])
        );

        assign issue_valid[k]                 = sel_found[k];
        assign issue_pkt[k*ISSUE_W +: ISSUE_W] = sel_found[k] ? to_issue(ent_q[sel_idx[k]]) : '0;
    end

    // Next state: wakeup, issue completion, dispatch, then flush overrides all.
    always_comb begin
        valid_d = valid_q;
        ent_d   = ent_q;
        fu_d    = fu_q;
        rr_d    = rr_q;

        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (valid_q[i]) begin
                {ent_d[i].rs1_rdy, ent_d[i].rs1_val} =
                    wake(ent_q[i].rs1_tag, ent_q[i].rs1_rdy, ent_q[i].rs1_val,
                         cdb_valid, cdb_tag, cdb_val);
                {ent_d[i].rs2_rdy, ent_d[i].rs2_val} =
                    wake(ent_q[i].rs2_tag, ent_q[i].rs2_rdy, ent_q[i].rs2_val,
                         cdb_valid, cdb_tag, cdb_val);
            end
        end

        for (int k = 0; k < NUM_FU; k++) begin
            if (sel_found[k] && fu_ready[k]) begin
                valid_d[sel_idx[k]] = 1'b0;
            end
        end

        // free_idx_c comes from registered state, so a slot freed this cycle is not reused.
        if (disp_valid && disp_ready) begin
            valid_d[free_idx_c] = 1'b1;
            ent_d[free_idx_c]   = disp_ent_c;
            fu_d[free_idx_c]    = rr_q;
            rr_d                = (rr_q == FU_W'(NUM_FU - 1)) ? '0 : rr_q + FU_W'(1);
        end

        if (flush) begin
            valid_d = '0;
            rr_d    = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            rr_q    <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                ent_q[i] <= '0;
                fu_q[i]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            rr_q    <= rr_d;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
                fu_q[i]  <= fu_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wakeup_issue_queue.sv
// Self-checking bench for wakeup_issue_queue: directed scenarios plus a
// randomized phase, all checked every cycle against a slot-level queue model.
module tb_wakeup_issue_queue;
    import iq_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned NFU   = 3;
    localparam int unsigned NCDB  = 2;

    logic                      clk;
    logic                      reset_n;
    logic                      disp_valid;
    logic                      disp_ready;
    logic [OPC_BITS-1:0]       disp_opcode;
    logic [PREG_BITS-1:0]      disp_dest, disp_rs1, disp_rs2;
    logic [XLEN-1:0]           disp_rs1_val, disp_rs2_val, disp_imm;
    logic                      disp_rs1_rdy, disp_rs2_rdy;
    logic [ROB_BITS-1:0]       disp_rob;
    logic [NCDB-1:0]           cdb_valid;
    logic [NCDB*PREG_BITS-1:0] cdb_tag;
    logic [NCDB*XLEN-1:0]      cdb_val;
    logic [NFU-1:0]            fu_ready;
    logic [NFU-1:0]            issue_valid;
    logic [NFU*ISSUE_W-1:0]    issue_pkt;
    logic                      flush;
    logic [$clog2(DEPTH):0]    iq_count;

    int n_cmp = 0;
    int n_err = 0;

    wakeup_issue_queue #(.IQ_DEPTH(DEPTH), .NUM_FU(NFU), .NUM_CDB(NCDB)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_opcode  (disp_opcode),
        .disp_dest    (disp_dest),
        .disp_rs1     (disp_rs1),
        .disp_rs2     (disp_rs2),
        .disp_rs1_val (disp_rs1_val),
        .disp_rs2_val (disp_rs2_val),
        .disp_rs1_rdy (disp_rs1_rdy),
        .disp_rs2_rdy (disp_rs2_rdy),
        .disp_imm     (disp_imm),
        .disp_rob     (disp_rob),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_val      (cdb_val),
        .fu_ready     (fu_ready),
        .issue_valid  (issue_valid),
        .issue_pkt    (issue_pkt),
        .flush        (flush),
        .iq_count     (iq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit        m_valid [DEPTH];
    iq_entry_t m_ent   [DEPTH];
    int        m_fu    [DEPTH];
    int        m_rr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) if (m_valid[i]) c++;
        return c;
    endfunction

    function automatic int m_sel(input int k);
        for (int i = 0; i < DEPTH; i++)
            if (m_valid[i] && m_ent[i].rs1_rdy && m_ent[i].rs2_rdy && m_fu[i] == k) return i;
        return -1;
    endfunction

    // First bus (lowest index) carrying the tag supplies the value.
    function automatic logic [XLEN:0] m_wake(input logic [PREG_BITS-1:0] tag,
                                             input logic rdy, input logic [XLEN-1:0] val);
        if (rdy) return {1'b1, val};
        for (int b = 0; b < NCDB; b++)
            if (cdb_valid[b] && cdb_tag[b*PREG_BITS +: PREG_BITS] == tag)
                return {1'b1, cdb_val[b*XLEN +: XLEN]};
        return {1'b0, val};
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        m_rr = 0;
    endtask

    // Apply one clock edge's worth of behaviour using the inputs now driven.
    task automatic model_edge();
        int        sel [NFU];
        int        fr;
        bit        acc;
        iq_entry_t d;
        for (int k = 0; k < NFU; k++) sel[k] = m_sel(k);
        fr = -1;
        for (int i = 0; i < DEPTH; i++) if (!m_valid[i] && fr < 0) fr = i;
        acc = disp_valid && (m_count() < DEPTH) && !flush;
        if (flush) begin
            m_reset();
            return;
        end
        for (int k = 0; k < NFU; k++)
            if (sel[k] >= 0 && fu_ready[k]) m_valid[sel[k]] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i]) begin
                {m_ent[i].rs1_rdy, m_ent[i].rs1_val} = m_wake(m_ent[i].rs1_tag, m_ent[i].rs1_rdy, m_ent[i].rs1_val);
                {m_ent[i].rs2_rdy, m_ent[i].rs2_val} = m_wake(m_ent[i].rs2_tag, m_ent[i].rs2_rdy, m_ent[i].rs2_val);
            end
        end
        if (acc) begin
            d.opcode  = disp_opcode;
            d.dest    = disp_dest;
            d.rs1_tag = disp_rs1;
            d.rs2_tag = disp_rs2;
            d.imm     = disp_imm;
            d.rob     = disp_rob;
            {d.rs1_rdy, d.rs1_val} = m_wake(disp_rs1, disp_rs1_rdy, disp_rs1_val);
            {d.rs2_rdy, d.rs2_val} = m_wake(disp_rs2, disp_rs2_rdy, disp_rs2_val);
            m_ent[fr]   = d;
            m_valid[fr] = 1'b1;
            m_fu[fr]    = m_rr;
            m_rr        = (m_rr + 1) % NFU;
        end
    endtask

    function automatic issue_pkt_t pkt_of(input int k);
        issue_pkt_t p;
        p = issue_pkt[k*ISSUE_W +: ISSUE_W];
        return p;
    endfunction

    task automatic compare_all();
        issue_pkt_t e;
        int         s;
        check("disp_ready", 128'(disp_ready), 128'(m_count() < DEPTH));
        check("iq_count", 128'(iq_count), 128'(m_count()));
        for (int k = 0; k < NFU; k++) begin
            s = m_sel(k);
            e = '0;
            if (s >= 0) e = to_issue(m_ent[s]);
            check($sformatf("issue_valid[%0d]", k), 128'(issue_valid[k]), 128'(s >= 0));
            check($sformatf("issue_pkt[%0d]", k), 128'(pkt_of(k)), 128'(e));
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = '0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [ROB_BITS-1:0] rob,
                        input logic [PREG_BITS-1:0] t1, input logic r1,
                        input logic [PREG_BITS-1:0] t2, input logic r2);
        disp_valid   = 1'b1;
        disp_opcode  = OPC_BITS'($urandom);
        disp_dest    = PREG_BITS'($urandom);
        disp_rs1     = t1;
        disp_rs1_rdy = r1;
        disp_rs1_val = $urandom;
        disp_rs2     = t2;
        disp_rs2_rdy = r2;
        disp_rs2_val = $urandom;
        disp_imm     = $urandom;
        disp_rob     = rob;
    endtask

    task automatic cdb(input int bus, input logic [PREG_BITS-1:0] tag, input logic [XLEN-1:0] val);
        cdb_valid[bus]                        = 1'b1;
        cdb_tag[bus*PREG_BITS +: PREG_BITS]   = tag;
        cdb_val[bus*XLEN +: XLEN]             = val;
    endtask

    initial begin
        int guard;
        reset_n = 1'b0;
        idle();
        disp(0, 0, 1'b1, 0, 1'b1);
        disp_valid = 1'b0;
        cdb_tag  = '0;
        cdb_val  = '0;
        fu_ready = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_count", 128'(iq_count), 128'(0));
        check("reset_ready", 128'(disp_ready), 128'(1));
        check("reset_issue_valid", 128'(issue_valid), 128'(0));
        check("reset_issue_pkt", 128'(issue_pkt), 128'(0));
        reset_n = 1'b1;

        // Three ready ops go round-robin to FU0/1/2, each issuing the next cycle.
        fu_ready = 3'b111;
        disp(0, 1, 1'b1, 2, 1'b1); cycle(); check("t1_fu0", 128'(issue_valid), 128'(3'b001));
        disp(1, 1, 1'b1, 2, 1'b1); cycle(); check("t1_fu1", 128'(issue_valid), 128'(3'b010));
        disp(2, 1, 1'b1, 2, 1'b1); cycle(); check("t1_fu2", 128'(issue_valid), 128'(3'b100));
        idle(); cycle(); check("t1_empty", 128'(iq_count), 128'(0));

        // Unready rs1 woken by CDB0.
        disp(3, 12, 1'b0, 5, 1'b1); cycle(); check("t2_wait", 128'(issue_valid), 128'(0));
        idle(); cycle();
        cdb(0, 12, 32'hDEAD_BEEF); cycle();
        idle();
        check("t2_woke", 128'(issue_valid[0]), 128'(1));
        check("t2_rs1_val", 128'(pkt_of(0).rs1_val), 128'(32'hDEAD_BEEF));
        cycle();

        // Same-cycle wakeup at dispatch on CDB1 (entry goes to FU1).
        disp(4, 20, 1'b0, 7, 1'b1); cdb(1, 20, 32'h1234_5678); cycle();
        idle();
        check("t3_iv1", 128'(issue_valid[1]), 128'(1));
        check("t3_rs1_val", 128'(pkt_of(1).rs1_val), 128'(32'h1234_5678));
        cycle();

        // Fill to full, drop a 17th dispatch, then free one slot.
        for (int i = 0; i < DEPTH; i++) begin
            disp(ROB_BITS'(i), 40, 1'b0, 3, 1'b1); cycle();
        end
        check("t4_full_ready", 128'(disp_ready), 128'(0));
        check("t4_full_count", 128'(iq_count), 128'(DEPTH));
        disp(63, 40, 1'b0, 3, 1'b1); cycle();
        check("t4_drop_count", 128'(iq_count), 128'(DEPTH));
        idle(); fu_ready = 3'b001; cdb(0, 40, 32'h0000_A5A5); cycle();
        idle(); cycle();
        check("t4_after_issue_ready", 128'(disp_ready), 128'(1));
        check("t4_after_issue_count", 128'(iq_count), 128'(DEPTH - 1));
        fu_ready = 3'b111;
        guard = 0;
        while (m_count() != 0 && guard < 20) begin cycle(); guard++; end
        check("t4_drained", 128'(iq_count), 128'(0));

        // Flush with 5 entries plus a concurrent dispatch.
        fu_ready = 3'b000;
        for (int i = 0; i < 5; i++) begin disp(ROB_BITS'(20 + i), 1, 1'b1, 2, 1'b1); cycle(); end
        check("t6_pre_count", 128'(iq_count), 128'(5));
        disp(30, 1, 1'b1, 2, 1'b1); flush = 1'b1; cycle();
        check("t6_flush_count", 128'(iq_count), 128'(0));
        check("t6_flush_iv", 128'(issue_valid), 128'(0));
        idle(); fu_ready = 3'b111; disp(9, 1, 1'b1, 2, 1'b1); cycle();
        check("t6_rr_reset", 128'(issue_valid), 128'(3'b001));
        idle(); cycle();

        // Two FU0 entries held while fu_ready[0]=0; lower slot stays selected.
        flush = 1'b1; cycle(); idle();
        fu_ready = 3'b110;
        disp(10, 1, 1'b1, 2, 1'b1); cycle();
        disp(11, 1, 1'b1, 2, 1'b1); cycle();
        disp(12, 1, 1'b1, 2, 1'b1); cycle();
        disp(13, 1, 1'b1, 2, 1'b1); cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t5_hold_rob", 128'(pkt_of(0).rob), 128'(10));
        end
        fu_ready = 3'b111; cycle();
        check("t5_second_rob", 128'(pkt_of(0).rob), 128'(13));
        cycle();
        check("t5_done", 128'(issue_valid[0]), 128'(0));

        // Randomized traffic with small tag space so wakeups collide often.
        for (int c = 0; c < 600; c++) begin
            idle();
            if ($urandom_range(2) != 0)
                disp(ROB_BITS'($urandom), PREG_BITS'($urandom_range(7)), 1'($urandom),
                     PREG_BITS'($urandom_range(7)), 1'($urandom));
            for (int b = 0; b < NCDB; b++)
                if ($urandom_range(1) != 0) cdb(b, PREG_BITS'($urandom_range(7)), $urandom);
            fu_ready = NFU'($urandom);
            flush    = ($urandom_range(63) == 0);
            cycle();
        end

        // Asynchronous reset mid-operation.
        idle(); fu_ready = '0;
        disp(50, 1, 1'b1, 2, 1'b1); cycle();
        disp(51, 1, 1'b1, 2, 1'b1); cycle();
        idle();
        #2 reset_n = 1'b0;
        #1;
        m_reset();
        check("async_rst_count", 128'(iq_count), 128'(0));
        check("async_rst_iv", 128'(issue_valid), 128'(0));
        check("async_rst_ready", 128'(disp_ready), 128'(1));
        @(posedge clk); #1;
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
